conv_32_8: RTL and testbench
============================

Name: conv_32_8

Overview:
- Serializer that turns 32-bit words into a stream of 8-bit bytes, most significant byte first.
- It is the transmit-side counterpart of the 8-to-32 byte assembler. The assembler rebuilds each word from four consecutive valid bytes, so this block must emit exactly that ordering and framing.
- It sits between a word-wide source (e.g. a FIFO read side) and a byte-wide link, with valid/ready flow control on both sides.

Parameters:
- WORD_W, 32, input word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8, output byte width.
- NBYTES, WORD_W/BYTE_W (4), bytes per word; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_L  input  1  asynchronous, active-low reset
- valid_in  input  1  upstream word valid
- data_in  input  WORD_W  upstream word
- ready_out  output  1  block can accept a word this cycle
- data_out  output  BYTE_W  current byte, registered
- valid_out  output  1  data_out valid, registered
- ready_in  input  1  downstream accepts the byte this cycle

Behaviour:
- Reset (reset_L=0, asynchronous): valid_out=0, data_out=0, byte counter=0, holding-buffer valid=0, state=IDLE, ready_out=0.
  - After release: ready_out=1 in the first cycle.
  - A partially sent word is discarded. After reset, sending always restarts at the MSB of a fresh word.
- Handshakes:
  - Word accept = valid_in && ready_out at a rising edge.
  - Byte transfer = valid_out && ready_in at a rising edge.
  - Upstream must hold valid_in/data_in stable while ready_out=0. The block never drops an accepted word.
- States:
  - IDLE: valid_out=0.
  - SEND: valid_out=1; counter cnt (0..NBYTES-1) indexes the byte being presented.
- IDLE -> SEND on word accept:
  - The word loads into shift register shreg.
  - data_out = data_in[WORD_W-1 -: BYTE_W]; cnt=0.
  - Latency: word accepted at edge N gives its first byte valid in the cycle after edge N.
- In SEND, on byte transfer with cnt<NBYTES-1: shreg shifts left by BYTE_W, data_out takes the next byte, cnt increments.
- In SEND, on byte transfer with cnt==NBYTES-1 (last byte):
  - If a next word is available (accepted at this same edge, or held in the buffer), load it and present its MSB with valid_out=1. No bubble; stay in SEND.
  - Otherwise go to IDLE with valid_out=0.
- Stall: while ready_in=0 in SEND, data_out, valid_out and cnt hold exactly.
- data_out in IDLE holds its last value (0 after reset).
- cnt wraps NBYTES-1 -> 0 only at a word boundary.
- Width rules: cnt is $clog2(NBYTES) bits. No arithmetic beyond the increment.

Optional Feature:
- Macro: CONV_HOLD_BUF_EN.
- Defined:
  - Adds a one-word holding register (buffer valid flag + WORD_W data).
  - ready_out = !buf_valid, registered, with no combinational path from ready_in.
  - A word accepted while SEND is busy goes into the buffer. The buffer drains into shreg at the last-byte transfer.
  - Simultaneous buffer drain and new accept at one edge is legal: the buffer refills.
- Undefined:
  - No buffer.
  - ready_out = !valid_out || (cnt==NBYTES-1 && ready_in), a combinational path from ready_in to ready_out.
  - Back-to-back streaming without bubbles is still required when ready_in stays 1.

Decomposition:
- Package conv_pkg holds:
  - WORD_W/BYTE_W defaults and derived NBYTES;
  - counter width;
  - state encoding (IDLE, SEND).
- Sub-module conv_hold_buf: one-entry skid/holding buffer with valid/ready on both sides. Instantiated only under CONV_HOLD_BUF_EN.

Test Plan:
- Single word: 0xDEADBEEF, ready_in=1 -> data_out DE, AD, BE, EF on 4 consecutive cycles with valid_out=1, then valid_out=0.
- Back-to-back: 0x01020304 then 0xA0B0C0D0, valid_in held -> 8 contiguous bytes 01,02,03,04,A0,B0,C0,D0 with no valid_out gap. ready_out=1 only on the accept cycles.
- Downstream stall: 0xDEADBEEF, ready_in=0 for 3 cycles while 0xAD is presented -> 0xAD and valid_out stay stable, then BE, EF follow. Exactly 4 transfers counted.
- Buffer, with CONV_HOLD_BUF_EN defined: words A=0x11223344, B=0x55667788, C=0x99AABBCC offered while ready_in=0.
  - A and B are accepted; ready_out drops; C is held off.
  - On release of ready_in: 11..44, 55..88 are sent without a gap, and C is accepted once the buffer frees.
- Reset mid-word: reset_L=0 while 0xBE of 0xDEADBEEF is presented -> valid_out=0 and data_out=00 immediately, without waiting for a clock edge.
  - After release, word 0xCAFEF00D emits CA first.
- Ignored input: valid_in=1 with ready_out=0, data_in changing illegally -> only the value present at the accept edge is sent.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults, derived sizes and state encoding for the 32-to-8 serializer.
package conv_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int NBYTES_DEF = WORD_W_DEF / BYTE_W_DEF;

  // Byte-index counter width; kept at least one bit so a 1-byte word still builds.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(NBYTES_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/conv_hold_buf.sv
// One-entry holding buffer with bypass: an empty buffer passes a word straight
// through when the consumer takes it in the same cycle. Used only with CONV_HOLD_BUF_EN.
`ifdef CONV_HOLD_BUF_EN
module conv_hold_buf
  import conv_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  input  logic              rd_ready
);

  logic              buf_valid_r;
  logic [WORD_W-1:0] buf_data_r;
  logic              buf_valid_nxt_s;
  logic [WORD_W-1:0] buf_data_nxt_s;
  logic              wr_fire_s;

  assign wr_ready  = !buf_valid_r;
  assign wr_fire_s = wr_valid && !buf_valid_r;
  assign rd_valid  = buf_valid_r || wr_valid;
  assign rd_data   = buf_valid_r ? buf_data_r : wr_data;

  // Next buffer contents: drain (with optional refill) or capture when not bypassed.
  always_comb begin
    buf_valid_nxt_s = buf_valid_r;
    buf_data_nxt_s  = buf_data_r;
    if (buf_valid_r && rd_ready) begin
      buf_valid_nxt_s = wr_fire_s;
      buf_data_nxt_s  = wr_data;
    end else if (!buf_valid_r && wr_fire_s && !rd_ready) begin
      buf_valid_nxt_s = 1'b1;
      buf_data_nxt_s  = wr_data;
    end else begin
      buf_valid_nxt_s = buf_valid_r;
      buf_data_nxt_s  = buf_data_r;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      buf_valid_r <= 1'b0;
      buf_data_r  <= {WORD_W{1'b0}};
    end else begin
      buf_valid_r <= buf_valid_nxt_s;
      buf_data_r  <= buf_data_nxt_s;
    end
  end

endmodule
`endif

// File: rtl/conv_32_8.sv
// Word-to-byte serializer, MSB first, valid/ready on both sides.
// Define CONV_HOLD_BUF_EN to add a one-word holding buffer with a registered ready_out.
module conv_32_8
  import conv_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in
);

  localparam int              NBYTES   = WORD_W / BYTE_W;
  localparam int              CNT_W    = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  state_e            state_r, state_nxt_s;
  logic [WORD_W-1:0] shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              xfer_s, last_s, slot_s;
  logic              word_avail_s;
  logic [WORD_W-1:0] word_data_s;

  assign valid_out = (state_r == ST_SEND);
  assign data_out  = shreg_r[WORD_W-1 -: BYTE_W];
  assign xfer_s    = valid_out && ready_in;
  assign last_s    = (cnt_r == CNT_LAST);
  // A new word may enter shreg when idle or as the last byte leaves.
  assign slot_s    = (state_r == ST_IDLE) || (xfer_s && last_s);

`ifdef CONV_HOLD_BUF_EN
  logic buf_wr_ready_s;

  conv_hold_buf #(
    .WORD_W(WORD_W)
  ) u_hold_buf (
    .clk      (clk),
    .reset_L  (reset_L),
    .wr_valid (valid_in),
    .wr_data  (data_in),
    .wr_ready (buf_wr_ready_s),
    .rd_valid (word_avail_s),
    .rd_data  (word_data_s),
    .rd_ready (slot_s)
  );

  assign ready_out = reset_L && buf_wr_ready_s;
`else
  assign ready_out    = reset_L && slot_s;
  assign word_avail_s = valid_in && ready_out;
  assign word_data_s  = data_in;
`endif

  // Next-state: load a fresh word, shift to the next byte, or fall idle.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    cnt_nxt_s   = cnt_r;
    if (slot_s && word_avail_s) begin
      state_nxt_s = ST_SEND;
      shreg_nxt_s = word_data_s;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else if (xfer_s && !last_s) begin
      shreg_nxt_s = {shreg_r[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      cnt_nxt_s   = cnt_r + CNT_W'(1);
    end else if (xfer_s) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      state_nxt_s = state_r;
      shreg_nxt_s = shreg_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // State, shift register and byte counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
      shreg_r <= {WORD_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      shreg_r <= shreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_conv_32_8.sv
// Scoreboard bench for conv_32_8: accepted words expand into expected bytes,
// transferred bytes are popped and compared. Honors CONV_HOLD_BUF_EN.
module tb_conv_32_8;

  localparam int NBYTES = 4;
`ifdef CONV_HOLD_BUF_EN
  localparam int B2B_WAIT = 1;
`else
  localparam int B2B_WAIT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_L;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;
  int n_bubble = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  conv_32_8 dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: pop on byte transfer, push on word accept.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (reset_L) begin
      if (!valid_out && sb.size() != 0) n_bubble++;
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", {31'd0, valid_out}, 32'd0);
        end else begin
          exp_b = sb.pop_front();
          chk("byte", {24'd0, data_out}, {24'd0, exp_b});
          n_xfer++;
        end
      end
      if (valid_in && ready_out)
        for (int i = NBYTES - 1; i >= 0; i--) sb.push_back(data_in[i*8 +: 8]);
    end
  end

  task automatic offer(input logic [31:0] w, input string tag, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    valid_in = 1'b1;
    data_in  = w;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      waited = k + 1;
      if (ready_out) done = 1'b1;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !valid_out) ok = 1'b1;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w_cnt;
    int x0;
    logic [31:0] w;

    reset_L  = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    data_in  = 32'd0;
    #1 reset_L = 1'b0;
    #1;
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_ready_out", {31'd0, ready_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    #1 chk("ready_after_rst", {31'd0, ready_out}, 32'd1);

    // Single word, MSB first, then idle holding the last byte.
    w = 32'hDEADBEEF;
    offer(w, "t1_accept", w_cnt);
    chk("t1_wait", 32'(w_cnt), 32'd1);
    for (int i = 0; i < NBYTES; i++) begin
      @(negedge clk);
      chk("t1_valid", {31'd0, valid_out}, 32'd1);
      chk("t1_byte", {24'd0, data_out}, {24'd0, w[31-8*i -: 8]});
    end
    @(negedge clk);
    chk("t1_idle", {31'd0, valid_out}, 32'd0);
    chk("t1_hold", {24'd0, data_out}, 32'h0000_00EF);
    drain("t1_drain");

    // Back-to-back words with valid_in held: eight contiguous bytes.
    x0 = n_xfer;
    offer(32'h01020304, "t2_accept_a", w_cnt);
    offer(32'hA0B0C0D0, "t2_accept_b", w_cnt);
    chk("t2_b_wait", 32'(w_cnt), 32'(B2B_WAIT));
    drain("t2_drain");
    chk("t2_xfers", 32'(n_xfer - x0), 32'd8);
    chk("t2_bubbles", 32'(n_bubble), 32'd0);

    // Downstream stall on the second byte.
    x0 = n_xfer;
    offer(32'hDEADBEEF, "t3_accept", w_cnt);
    @(negedge clk);
    chk("t3_first", {24'd0, data_out}, 32'h0000_00DE);
    @(posedge clk);
    #1 ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_data", {24'd0, data_out}, 32'h0000_00AD);
      chk("t3_stall_valid", {31'd0, valid_out}, 32'd1);
    end
    @(posedge clk);
    #1 ready_in = 1'b1;
    drain("t3_drain");
    chk("t3_xfers", 32'(n_xfer - x0), 32'd4);

    // Reset while 0xBE is presented, then a fresh word restarts at its MSB.
    offer(32'hDEADBEEF, "t4_accept", w_cnt);
    repeat (2) @(posedge clk);
    #1 chk("t4_pre_rst", {24'd0, data_out}, 32'h0000_00BE);
    reset_L = 1'b0;
    sb.delete();
    #1;
    chk("t4_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("t4_rst_data", {24'd0, data_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    offer(32'hCAFEF00D, "t4_accept2", w_cnt);
    @(negedge clk);
    chk("t4_msb", {24'd0, data_out}, 32'h0000_00CA);
    drain("t4_drain");

`ifdef CONV_HOLD_BUF_EN
    // Holding buffer: A to shreg, B to buffer, C held off until the buffer frees.
    ready_in = 1'b0;
    offer(32'h11223344, "t5_accept_a", w_cnt);
    offer(32'h55667788, "t5_accept_b", w_cnt);
    chk("t5_b_wait", 32'(w_cnt), 32'd1);
    valid_in = 1'b1;
    data_in  = 32'h99AABBCC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_full_ready", {31'd0, ready_out}, 32'd0);
      @(posedge clk);
      #1;
    end
    ready_in = 1'b1;
    offer(32'h99AABBCC, "t5_accept_c", w_cnt);
    chk("t5_c_wait", 32'(w_cnt), 32'd5);
    drain("t5_drain");
    chk("t5_bubbles", 32'(n_bubble), 32'd0);
`else
    // Illegal changes on data_in while ready_out=0 must not reach the output.
    offer(32'h10203040, "t5_accept_a", w_cnt);
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = $urandom;
      @(negedge clk);
      chk("t5_busy_ready", {31'd0, ready_out}, 32'd0);
      @(posedge clk);
      #1;
    end
    data_in = 32'h5A5B5C5D;
    @(negedge clk);
    chk("t5_last_ready", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1 valid_in = 1'b0;
    data_in = $urandom;
    @(negedge clk);
    chk("t5_next_msb", {24'd0, data_out}, 32'h0000_005A);
    drain("t5_drain");
`endif

    chk("total_bubbles", 32'(n_bubble), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
